// File: rtl/seg_display_pkg.sv
// Shared types and glyph helpers for the multiplexed seven-segment display controller.
package seg_display_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low glyphs, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per clock, 4*NUM_DIGITS clocks per conversion.
module bin2bcd_seq #(
  parameter int NUM_DIGITS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [4*NUM_DIGITS-1:0]      bin_i,
  output logic                         done_o,
  output logic [NUM_DIGITS-1:0][3:0]   bcd_o,
  output logic                         ovf_o
);
  localparam int W  = 4*NUM_DIGITS;
  localparam int CW = $clog2(W);

  logic [W-1:0]                bin_q, bin_d;
  logic [NUM_DIGITS-1:0][3:0]  bcd_q, bcd_d, adj;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        ovf_q, ovf_d, busy_q, busy_d, last;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
    last  = busy_q && (cnt_q == CW'(W-1));
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    busy_d = busy_q;
    if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // A 1 leaving the top digit means the value needs more digits than we have.
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      ovf_d  = ovf_q | adj[NUM_DIGITS-1][3];
      cnt_d  = cnt_q + 1'b1;
      busy_d = !last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = last;
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;
endmodule

// File: rtl/seg_scan_display_ctrl.sv
// Multiplexed seven-segment controller: load handshake, hex/decimal display,
// leading-zero blanking, overflow dashes and PWM-dimmed anode scan.
module seg_scan_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 800
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] number,
  input  logic                    dec_mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [3:0]              bright,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    ready,
  output logic                    ovf
);
  localparam int DIV   = CLK_HZ / (SCAN_HZ * 16);
  localparam int DIV_C = (DIV < 1) ? 1 : DIV;
  localparam int PW    = (DIV_C > 1) ? $clog2(DIV_C) : 1;
  localparam int CUR_W = $clog2(NUM_DIGITS);

  state_e                      state_q, state_d;
  logic                        ready_q, accept, start, conv_done, conv_ovf;
  logic [NUM_DIGITS-1:0][3:0]  num_q, dig_q, bcd;
  logic [NUM_DIGITS-1:0]       dp_q, ddp_q, lz;
  logic                        dec_q, blz_q, dblz_q, dovf_q, allz;
  logic [PW-1:0]               presc_q;
  logic [3:0]                  pwm_q;
  logic [CUR_W-1:0]            cur_q;
  logic                        tick;
  logic [6:0]                  seg_q, seg_d;
  logic                        seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;

  assign accept = load && ready_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = dec_mode ? ST_SHIFT : ST_COMMIT;
        start   = dec_mode;
      end
      ST_SHIFT:  if (conv_done) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      // Held low through the COMMIT cycle so the new value is on the glass before the next load.
      ready_q <= (state_q == ST_IDLE) && !accept;
    end
  end

  bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS)) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .bin_i   (number),
    .done_o  (conv_done),
    .bcd_o   (bcd),
    .ovf_o   (conv_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q  <= '0;
      dec_q  <= 1'b0;
      blz_q  <= 1'b0;
      dp_q   <= '0;
      dig_q  <= '0;
      ddp_q  <= '0;
      dblz_q <= 1'b0;
      dovf_q <= 1'b0;
    end else begin
      if (accept) begin
        num_q <= number;
        dec_q <= dec_mode;
        blz_q <= blank_lz;
        dp_q  <= dp;
      end
      if (state_q == ST_COMMIT) begin
        dig_q  <= dec_q ? bcd : num_q;
        dovf_q <= dec_q & conv_ovf;
        ddp_q  <= dp_q;
        dblz_q <= blz_q;
      end
    end
  end

  assign tick = (presc_q == PW'(DIV_C-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pwm_q   <= '0;
      cur_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        pwm_q <= pwm_q + 4'd1;
        if (pwm_q == 4'hF)
          cur_q <= (cur_q == CUR_W'(NUM_DIGITS-1)) ? '0 : cur_q + 1'b1;
      end
    end
  end

  // lz[i]: digits i..N-1 are all zero.
  always_comb begin
    lz   = '0;
    allz = 1'b1;
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      allz  = allz && (dig_q[i] == 4'd0);
      lz[i] = allz;
    end
  end

  always_comb begin
    seg_d    = hex_to_seg(dig_q[cur_q]);
    seg_dp_d = ~ddp_q[cur_q];
    if (dovf_q) begin
      seg_d    = SEG_DASH;
      seg_dp_d = 1'b1;
    end else if (dblz_q && lz[cur_q]) begin
      seg_d = SEG_BLANK;
    end
    an_d = '1;
    if (pwm_q <= bright) an_d[cur_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= SEG_BLANK;
      seg_dp_q <= 1'b1;
      an_q     <= '1;
    end else begin
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      an_q     <= an_d;
    end
  end

  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;
  assign an     = an_q;
  assign ready  = ready_q;
  assign ovf    = dovf_q;
endmodule

// File: tb/tb_seg_scan_display_ctrl.sv
// Randomized and directed bench for seg_scan_display_ctrl against an arithmetic display model.
module tb_seg_scan_display_ctrl;
  localparam int N    = 8;
  localparam int N5   = 5;
  localparam int SLOT = 128;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            load = 1'b0, dec_mode = 1'b0, blank_lz = 1'b0;
  logic [4*N-1:0]  number = '0;
  logic [N-1:0]    dp = '0;
  logic [3:0]      bright = 4'd15;
  logic [6:0]      seg;
  logic            seg_dp, ready, ovf;
  logic [N-1:0]    an;

  logic            load5 = 1'b0, dec5 = 1'b0, blz5 = 1'b0;
  logic [4*N5-1:0] number5 = '0;
  logic [N5-1:0]   dp5 = '0;
  logic [3:0]      bright5 = 4'd15;
  logic [6:0]      seg5;
  logic            seg_dp5, ready5, ovf5;
  logic [N5-1:0]   an5;

  int total = 0, bad = 0;
  int ecnt;

  longint unsigned m_num = 0;
  bit              m_dec = 0, m_blz = 0;
  logic [N-1:0]    m_dp = '0;

  seg_scan_display_ctrl #(.NUM_DIGITS(N), .CLK_HZ(1280), .SCAN_HZ(10)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .number(number), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .dp(dp), .bright(bright), .seg(seg), .seg_dp(seg_dp),
    .an(an), .ready(ready), .ovf(ovf));

  seg_scan_display_ctrl #(.NUM_DIGITS(N5), .CLK_HZ(1280), .SCAN_HZ(10)) dut5 (
    .clk(clk), .rst_n(rst_n), .load(load5), .number(number5), .dec_mode(dec5),
    .blank_lz(blz5), .dp(dp5), .bright(bright5), .seg(seg5), .seg_dp(seg_dp5),
    .an(an5), .ready(ready5), .ovf(ovf5));

  always #5 clk = ~clk;

  // Edges since reset release; the scan timing is a pure function of this.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic longint unsigned pw(input longint unsigned b, input int e);
    longint unsigned r = 1;
    for (int k = 0; k < e; k++) r = r * b;
    return r;
  endfunction

  function automatic bit exp_ovf();
    return m_dec && (m_num >= pw(10, N));
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    longint unsigned base = m_dec ? 64'd10 : 64'd16;
    longint unsigned hi   = m_num / pw(base, i);
    if (exp_ovf()) return 7'h3F;
    if (m_blz && i > 0 && hi == 0) return 7'h7F;
    return glyph(int'(hi % base));
  endfunction

  function automatic bit exp_dp(input int i);
    if (exp_ovf()) return 1'b1;
    return !m_dp[i];
  endfunction

  function automatic int cur_slot(input int nd);
    return ((ecnt - 1) / SLOT) % nd;
  endfunction

  function automatic logic [N-1:0] exp_an();
    logic [N-1:0] r = '1;
    if (((ecnt - 1) / 8) % 16 <= int'(bright)) r[cur_slot(N)] = 1'b0;
    return r;
  endfunction

  function automatic logic [N5-1:0] exp_an5();
    logic [N5-1:0] r = '1;
    if (((ecnt - 1) / 8) % 16 <= int'(bright5)) r[cur_slot(N5)] = 1'b0;
    return r;
  endfunction

  task automatic wait_phase(input int ph);
    int g = 0;
    while ((ecnt % SLOT) != ph && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) chk("phase_timeout", g, 0);
  endtask

  // Visit nslots digit slots mid-dwell and compare everything that is on the pins.
  task automatic check_disp(input string tag, input int nslots);
    for (int k = 0; k < nslots; k++) begin
      wait_phase(64);
      chk({tag, "_seg"}, seg, exp_seg(cur_slot(N)));
      chk({tag, "_dp"}, seg_dp, exp_dp(cur_slot(N)));
      chk({tag, "_an"}, an, exp_an());
      chk({tag, "_an5"}, an5, exp_an5());
      @(negedge clk);
    end
    chk({tag, "_ovf"}, ovf, exp_ovf());
  endtask

  task automatic do_load(input string tag, input longint unsigned v, input bit d, input bit b,
                         input logic [N-1:0] p, input int exp_low, input bit inject);
    int lo = 0;
    @(negedge clk);
    chk({tag, "_rdy_pre"}, ready, 1'b1);
    number = v[4*N-1:0]; dec_mode = d; blank_lz = b; dp = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while (ready !== 1'b1 && lo < 200) begin
      lo++;
      if (lo == 10) begin
        chk({tag, "_hold_seg"}, seg, exp_seg(cur_slot(N)));
        chk({tag, "_hold_ovf"}, ovf, exp_ovf());
      end
      if (inject && lo == 5) begin
        number = 32'd999; dec_mode = 1'b0; dp = '1; load = 1'b1;
      end
      if (lo == 6) load = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_rdy_low"}, lo, exp_low);
    m_num = v; m_dec = d; m_blz = b; m_dp = p;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", an, {N{1'b1}});
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", seg_dp, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_an5", an5, {N5{1'b1}});
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", ready, 1'b1);
    check_disp("walk", 11);

    do_load("hex", 64'hDEADBEEF, 1'b0, 1'b0, '0, 2, 1'b0);
    check_disp("hex", N);

    do_load("dec", 64'd12345, 1'b1, 1'b1, 8'h04, 34, 1'b0);
    check_disp("dec", N);

    do_load("ovf", 64'd100_000_000, 1'b1, 1'b0, 8'hFF, 34, 1'b0);
    check_disp("ovf", N);
    do_load("clr", 64'd7, 1'b1, 1'b0, 8'h00, 34, 1'b0);
    check_disp("clr", N);

    do_load("inj", 64'd4321, 1'b1, 1'b1, 8'h01, 34, 1'b1);
    check_disp("inj", N);

    // Abort a conversion with reset while an overflow is on display.
    do_load("ovf2", 64'd999_999_999, 1'b1, 1'b0, '0, 34, 1'b0);
    chk("ovf2_flag", ovf, 1'b1);
    @(negedge clk);
    number = 32'd55; dec_mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", an, {N{1'b1}});
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_dp", seg_dp, 1'b1);
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_num = 0; m_dec = 0; m_blz = 0; m_dp = '0;
    do_load("zero", 64'd0, 1'b0, 1'b0, '0, 2, 1'b0);
    check_disp("zero", N);

    for (int r = 0; r < 6; r++) begin
      longint unsigned v;
      bit d = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: v = longint'($urandom_range(0, 99999));
        1: v = longint'($urandom % 100_000_000);
        default: v = longint'($urandom);
      endcase
      bright = 4'($urandom_range(0, 15));
      do_load("rnd", v, d, 1'($urandom_range(0, 1)), 8'($urandom), d ? 34 : 2, 1'b0);
      check_disp("rnd", N);
    end

    // Duty cycle over one full digit slot.
    begin
      int on = 0, s;
      bright = 4'd3;
      wait_phase(0);
      @(negedge clk);
      s = cur_slot(N);
      for (int k = 0; k < SLOT; k++) begin
        if (an == ~(8'(1) << s)) on++;
        else if (an != 8'hFF) on += 1000;
        @(negedge clk);
      end
      chk("duty3", on, 32);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
